// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port direction indices, output-stage FSM
// state encoding and the default flit width.
package noc_pkg;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEND  = 2'b01,
        STALL = 2'b10
    } out_state_t;

endpackage

// File: rtl/block_output_if.sv
// Connection bundle of the router output stage: request/grant/flit bus from the
// input controllers and the val/ret flit link toward the neighbour router.
interface block_output_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_PORT     = 5,
    parameter int STALL_W    = 8
);
    logic [N_PORT-1:0]            req;
    logic [N_PORT*DATA_WIDTH-1:0] Data_in;
    logic [N_PORT-1:0]            grant;
    logic                         val;
    logic                         ret;
    logic [DATA_WIDTH-1:0]        Data_out;
    logic [STALL_W-1:0]           stall_cnt;

    modport master (
        output req, Data_in, ret,
        input  grant, val, Data_out, stall_cnt
    );

    modport slave (
        input  req, Data_in, ret,
        output grant, val, Data_out, stall_cnt
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above ptr (wrapping)
// and returns the pointer just past the winner; ptr is returned unchanged on no grant.
module rr_arbiter #(
    parameter int N_PORT = 5,
    parameter int PTR_W  = 3
) (
    input  logic [N_PORT-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              en,
    output logic [N_PORT-1:0] grant,
    output logic [PTR_W-1:0]  next_ptr
);

    logic found_s;

    // Priority search starting at ptr; found_s blocks every later candidate.
    always_comb begin
        grant    = {N_PORT{1'b0}};
        next_ptr = ptr;
        found_s  = 1'b0;
        for (int i = 0; i < N_PORT; i++) begin
            int   idx;
            logic hit;
            idx        = (int'(ptr) + i) % N_PORT;
            hit        = en && !found_s && req[idx];
            grant[idx] = hit;
            found_s    = found_s | hit;
            next_ptr   = hit ? PTR_W'((idx + 1) % N_PORT) : next_ptr;
        end
    end

endmodule

// File: rtl/block_output.sv
// Router output stage: round-robin collection of routed flits into an output FIFO
// feeding the val/ret link. Macro BLOCK_OUTPUT_BYPASS_EN adds a 0-cycle path when empty.
module block_output
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N_PORT     = 5,
    parameter int DEPTH      = 4,
    parameter int STALL_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    block_output_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam logic [AW:0]          CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]          CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]          CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]        PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
    localparam logic [PW-1:0]        RR_ZERO   = PW'(0);
    localparam logic [STALL_W-1:0]   STALL_MAX = {STALL_W{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r, rd_ptr_r, wr_next_s, rd_next_s;
    logic [AW:0]           count_r, count_next_s;
    logic [PW-1:0]         rr_ptr_r, rr_next_s;
    logic [N_PORT-1:0]     grant_s;
    logic [DATA_WIDTH-1:0] push_data_s, data_r, head_next_s;
    logic [STALL_W-1:0]    stall_r, stall_next_s;
    logic                  val_r;
    logic                  full_s, arb_en_s, push_s, fifo_push_s, pop_s, xfer_s;
    logic                  empty_after_pop_s, last_pop_s;
    out_state_t            state_r, state_next_s;

    // Grants are suppressed in reset so no controller pops a flit that would be discarded.
    assign full_s   = (count_r == CNT_FULL);
    assign arb_en_s = rst && !full_s;

    rr_arbiter #(
        .N_PORT (N_PORT),
        .PTR_W  (PW)
    ) u_rr_arbiter (
        .req      (bus.req),
        .ptr      (rr_ptr_r),
        .en       (arb_en_s),
        .grant    (grant_s),
        .next_ptr (rr_next_s)
    );

    assign bus.grant = grant_s;
    assign push_s    = |grant_s;
    assign pop_s     = val_r && bus.ret;

    // One-hot AND-OR mux of the granted controller's flit.
    always_comb begin
        push_data_s = DATA_ZERO;
        for (int i = 0; i < N_PORT; i++) begin
            push_data_s = push_data_s
                        | (bus.Data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
        end
    end

`ifdef BLOCK_OUTPUT_BYPASS_EN
    logic byp_s;
    assign byp_s        = push_s && (count_r == CNT_ZERO);
    assign bus.val      = val_r | byp_s;
    assign bus.Data_out = byp_s ? push_data_s : data_r;
    assign fifo_push_s  = push_s && !(byp_s && bus.ret);
`else
    assign bus.val      = val_r;
    assign bus.Data_out = data_r;
    assign fifo_push_s  = push_s;
`endif

    assign xfer_s        = bus.val && bus.ret;
    assign bus.stall_cnt = stall_r;

    // Occupancy and pointer updates; push+pop leaves the count unchanged.
    always_comb begin
        case ({fifo_push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        wr_next_s = fifo_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    end

    // Next registered head: a flit landing in a FIFO that is empty after this pop
    // is not in memory yet, so it is taken straight from the push data.
    always_comb begin
        empty_after_pop_s = (count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s);
        if (fifo_push_s && empty_after_pop_s) begin
            head_next_s = push_data_s;
        end else if (count_next_s != CNT_ZERO) begin
            head_next_s = mem_r[rd_next_s];
        end else begin
            head_next_s = data_r;
        end
    end

    // Saturating count of stalled cycles, cleared by any transfer.
    always_comb begin
        if (xfer_s) begin
            stall_next_s = {STALL_W{1'b0}};
        end else if ((state_r == STALL) && !bus.ret && (stall_r != STALL_MAX)) begin
            stall_next_s = stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_next_s = stall_r;
        end
    end

    assign last_pop_s = pop_s && !fifo_push_s && (count_r == CNT_ONE);

    // Output FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                state_next_s = fifo_push_s ? SEND : IDLE;
            end
            SEND: begin
                if (last_pop_s) begin
                    state_next_s = IDLE;
                end else if (val_r && !bus.ret) begin
                    state_next_s = STALL;
                end else begin
                    state_next_s = SEND;
                end
            end
            STALL: begin
                if (!bus.ret) begin
                    state_next_s = STALL;
                end else if (last_pop_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (rst && fifo_push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            rr_ptr_r <= RR_ZERO;
            val_r    <= 1'b0;
            data_r   <= DATA_ZERO;
            stall_r  <= {STALL_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            rr_ptr_r <= rr_next_s;
            val_r    <= (count_next_s != CNT_ZERO);
            data_r   <= head_next_s;
            stall_r  <= stall_next_s;
        end
    end

endmodule

// File: tb/tb_block_output.sv
// Directed self-checking bench for block_output: table-driven reset/round-robin
// vectors plus hand-written full, push/pop, stall-saturation and reset sequences.
module tb_block_output;
    import noc_pkg::*;

    localparam int DW = 8;
    localparam int NP = 5;
    localparam int DP = 4;
    localparam int SW = 3;

    typedef struct {
        logic       r;
        logic [4:0] req;
        logic       ret;
        logic [3:0] tag;
        logic [4:0] g;
        logic       v;
        logic [7:0] d;
        logic       dchk;
        logic [2:0] s;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [8];
    int   full_stall [6] = '{0, 0, 0, 1, 2, 3};
    logic [7:0] full_flit [4] = '{8'h81, 8'h91, 8'hA1, 8'hB1};
    logic [7:0] pp_flit [4] = '{8'hC0, 8'hD0, 8'hE0, 8'hF0};

    block_output_if #(.DATA_WIDTH(DW), .N_PORT(NP), .STALL_W(SW)) bus_if ();

    block_output #(
        .DATA_WIDTH (DW),
        .N_PORT     (NP),
        .DEPTH      (DP),
        .STALL_W    (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; slice i carries {tag, i}.
    task automatic apply(input logic r, input logic [4:0] q, input logic t, input logic [3:0] tag);
        rst         = r;
        bus_if.req  = q;
        bus_if.ret  = t;
        for (int i = 0; i < NP; i++) begin
            bus_if.Data_in[i*DW +: DW] = {tag, 4'(i)};
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset cycles, release, then req=10101 round-robin draining one flit per cycle.
        tbl[0] = '{1'b0, 5'b11111, 1'b1, 4'h0, 5'b00000, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[1] = '{1'b0, 5'b11111, 1'b1, 4'h1, 5'b00000, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[2] = '{1'b1, 5'b11111, 1'b1, 4'h2, 5'b00001, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[3] = '{1'b1, 5'b10101, 1'b1, 4'h3, 5'b00100, 1'b1, 8'h20, 1'b1, 3'd0};
        tbl[4] = '{1'b1, 5'b10101, 1'b1, 4'h4, 5'b10000, 1'b1, 8'h32, 1'b1, 3'd0};
        tbl[5] = '{1'b1, 5'b10101, 1'b1, 4'h5, 5'b00001, 1'b1, 8'h44, 1'b1, 3'd0};
        tbl[6] = '{1'b1, 5'b00000, 1'b1, 4'h6, 5'b00000, 1'b1, 8'h50, 1'b1, 3'd0};
        tbl[7] = '{1'b1, 5'b00000, 1'b1, 4'h7, 5'b00000, 1'b0, 8'h00, 1'b0, 3'd0};

        apply(1'b0, 5'b11111, 1'b1, 4'h0);
        tick();

`ifdef BLOCK_OUTPUT_BYPASS_EN
        apply(1'b0, 5'b11111, 1'b1, 4'h0);
        check("byp_rst_grant", 32'(bus_if.grant), 32'h0);
        check("byp_rst_val", 32'(bus_if.val), 32'h0);
        tick();
        apply(1'b1, 5'b00001, 1'b1, 4'h7);
        check("byp_grant", 32'(bus_if.grant), 32'h01);
        check("byp_val_same_cycle", 32'(bus_if.val), 32'h1);
        check("byp_data_same_cycle", 32'(bus_if.Data_out), 32'h70);
        tick();
        apply(1'b1, 5'b00000, 1'b1, 4'h0);
        check("byp_val_after", 32'(bus_if.val), 32'h0);
        check("byp_count_after", 32'(dut.count_r), 32'h0);
        tick();
        apply(1'b1, 5'b00001, 1'b0, 4'h8);
        check("byp_stall_val", 32'(bus_if.val), 32'h1);
        check("byp_stall_data", 32'(bus_if.Data_out), 32'h80);
        tick();
        apply(1'b1, 5'b00000, 1'b0, 4'h0);
        check("byp_held_val", 32'(bus_if.val), 32'h1);
        check("byp_held_data", 32'(bus_if.Data_out), 32'h80);
        check("byp_held_count", 32'(dut.count_r), 32'h1);
        tick();
`else
        for (int k = 0; k < 8; k++) begin
            apply(tbl[k].r, tbl[k].req, tbl[k].ret, tbl[k].tag);
            check($sformatf("tbl%0d_grant", k), 32'(bus_if.grant), 32'(tbl[k].g));
            check($sformatf("tbl%0d_val", k), 32'(bus_if.val), 32'(tbl[k].v));
            check($sformatf("tbl%0d_stall", k), 32'(bus_if.stall_cnt), 32'(tbl[k].s));
            if (tbl[k].dchk) begin
                check($sformatf("tbl%0d_data", k), 32'(bus_if.Data_out), 32'(tbl[k].d));
            end
            tick();
        end

        // Fill to DEPTH with ret low: four grants, then back-pressure on the inputs.
        for (int c = 0; c < 6; c++) begin
            apply(1'b1, 5'b00010, 1'b0, 4'(8 + c));
            check($sformatf("full%0d_grant", c), 32'(bus_if.grant), (c < 4) ? 32'h02 : 32'h0);
            check($sformatf("full%0d_stall", c), 32'(bus_if.stall_cnt), 32'(full_stall[c]));
            if (c > 0) begin
                check($sformatf("full%0d_val", c), 32'(bus_if.val), 32'h1);
                check($sformatf("full%0d_head", c), 32'(bus_if.Data_out), 32'(full_flit[0]));
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 5'b00000, 1'b1, 4'h0);
            check($sformatf("drain%0d_val", c), 32'(bus_if.val), 32'h1);
            check($sformatf("drain%0d_data", c), 32'(bus_if.Data_out), 32'(full_flit[c]));
            check($sformatf("drain%0d_stall", c), 32'(bus_if.stall_cnt), (c == 0) ? 32'h4 : 32'h0);
            tick();
        end
        apply(1'b1, 5'b00000, 1'b1, 4'h0);
        check("drain_done_val", 32'(bus_if.val), 32'h0);
        check("drain_done_state", 32'(dut.state_r), 32'(IDLE));

        // Build count=2 with ret low, then push and pop together.
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 5'b00001, (c >= 2) ? 1'b1 : 1'b0, 4'(12 + c));
            check($sformatf("pp%0d_grant", c), 32'(bus_if.grant), 32'h01);
            if (c > 0) begin
                check($sformatf("pp%0d_data", c), 32'(bus_if.Data_out), (c == 3) ? 32'hD0 : 32'hC0);
            end
            if (c == 3) begin
                check("pp3_count", 32'(dut.count_r), 32'h2);
            end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 5'b00000, 1'b1, 4'h0);
            check($sformatf("ppd%0d_data", c), 32'(bus_if.Data_out), 32'(pp_flit[c + 2]));
            check($sformatf("ppd%0d_count", c), 32'(dut.count_r), (c == 0) ? 32'h2 : 32'h1);
            tick();
        end
        apply(1'b1, 5'b00000, 1'b1, 4'h0);
        check("pp_empty_val", 32'(bus_if.val), 32'h0);

        // One flit stuck with ret low: stall_cnt climbs and holds at 7.
        apply(1'b1, 5'b00001, 1'b0, 4'h3);
        check("sat_push_grant", 32'(bus_if.grant), 32'h01);
        tick();
        for (int k = 1; k < 12; k++) begin
            apply(1'b1, 5'b00000, 1'b0, 4'h0);
            check($sformatf("sat%0d_stall", k), 32'(bus_if.stall_cnt),
                  (k < 2) ? 32'h0 : ((k - 2 > 7) ? 32'h7 : 32'(k - 2)));
            tick();
        end
        apply(1'b1, 5'b00000, 1'b1, 4'h0);
        check("sat_xfer_val", 32'(bus_if.val), 32'h1);
        check("sat_xfer_data", 32'(bus_if.Data_out), 32'h30);
        check("sat_before_xfer", 32'(bus_if.stall_cnt), 32'h7);
        tick();
        apply(1'b1, 5'b00000, 1'b1, 4'h0);
        check("sat_cleared", 32'(bus_if.stall_cnt), 32'h0);
        check("sat_empty_val", 32'(bus_if.val), 32'h0);

        // Three flits buffered, then a single reset edge discards them.
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 5'b00010, 1'b0, 4'(c + 1));
            check($sformatf("mid%0d_grant", c), 32'(bus_if.grant), 32'h02);
            tick();
        end
        apply(1'b0, 5'b00010, 1'b1, 4'h9);
        check("mid_rst_grant", 32'(bus_if.grant), 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 5'b00000, 1'b1, 4'h0);
            check($sformatf("post_rst%0d_val", c), 32'(bus_if.val), 32'h0);
            check($sformatf("post_rst%0d_data", c), 32'(bus_if.Data_out), 32'h0);
            tick();
        end
        check("post_rst_count", 32'(dut.count_r), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
